// File: rtl/rca_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rca_pkg
// Description : Shared types and helpers for the ripple-carry sum accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package rca_pkg;

    localparam int SUM_W = 9;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    // Width of a counter that must hold values 0..count inclusive.
    function automatic int len_width(input int count);
        return $clog2(count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Single-bit full-adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/rca_n.sv
`default_nettype none
// ============================================================================
// Module      : rca_n
// Description : Parametric ripple-carry adder built from full-adder cells.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_n #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_carry[i]),
            .sum  (sum[i]),
            .cout (w_carry[i+1])
        );
    end

    assign cout = w_carry[W];

endmodule
`default_nettype wire

// File: rtl/rca8_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : rca8_sum_accumulator
// Description : Batches 9-bit adder results into a wide total with a sample
//               count and sticky overflow, under valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module rca8_sum_accumulator
    import rca_pkg::*;
#(
    parameter int COUNT = 4,
    parameter int ACC_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SUM_W-1:0]              in_sum,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          flush,
    output logic [ACC_W-1:0]              out_acc,
    output logic [len_width(COUNT)-1:0]   out_len,
    output logic                          out_ovf,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int c_len_w = len_width(COUNT);
    localparam int c_add_w = ACC_W + 1;
    localparam logic [c_len_w-1:0] c_last = c_len_w'(COUNT - 1);

    acc_state_t          r_state_q, w_state_d;
    logic [ACC_W-1:0]    r_acc_q,   w_acc_d;
    logic [c_len_w-1:0]  r_cnt_q,   w_cnt_d;
    logic                r_ovf_q,   w_ovf_d;

    logic [c_add_w-1:0]  w_add_a, w_add_b, w_add_sum;
    logic                w_add_cout;
    logic                w_accept;
    logic                w_carry;

    // One extra bit of width so the top bit of the sum is the wrap indicator.
    assign w_add_a = {1'b0, r_acc_q};
    assign w_add_b = {{(ACC_W - 8){1'b0}}, in_sum};

    rca_n #(
        .W (c_add_w)
    ) u_add (
        .a    (w_add_a),
        .b    (w_add_b),
        .cin  (1'b0),
        .sum  (w_add_sum),
        .cout (w_add_cout)
    );

    assign w_carry   = w_add_sum[ACC_W] | w_add_cout;
    assign in_ready  = (r_state_q == ACCUM) & ~rst;
    assign w_accept  = in_valid & in_ready;

    always_comb begin
        w_state_d = r_state_q;
        w_acc_d   = r_acc_q;
        w_cnt_d   = r_cnt_q;
        w_ovf_d   = r_ovf_q;
        case (r_state_q)
            ACCUM: begin
                if (w_accept) begin
                    w_acc_d = w_add_sum[ACC_W-1:0];
                    w_ovf_d = r_ovf_q | w_carry;
                    w_cnt_d = r_cnt_q + c_len_w'(1);
                end
                if ((w_accept && r_cnt_q == c_last) ||
                    (flush && (r_cnt_q != '0 || w_accept))) begin
                    w_state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_d = ACCUM;
                    w_acc_d   = '0;
                    w_cnt_d   = '0;
                    w_ovf_d   = 1'b0;
                end
            end
            default: w_state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ACCUM;
            r_acc_q   <= '0;
            r_cnt_q   <= '0;
            r_ovf_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_acc_q   <= w_acc_d;
            r_cnt_q   <= w_cnt_d;
            r_ovf_q   <= w_ovf_d;
        end
    end

    assign out_valid = (r_state_q == HOLD);
    assign out_acc   = r_acc_q;
    assign out_len   = r_cnt_q;
    assign out_ovf   = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_rca8_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca8_sum_accumulator
// Description : Directed self-checking bench; a 16-bit and a 10-bit instance
//               share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca8_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  in_sum;
    logic        in_valid;
    logic        flush;
    logic        out_ready;

    logic        a_in_ready, a_out_ovf, a_out_valid;
    logic [15:0] a_out_acc;
    logic [2:0]  a_out_len;
    logic        b_in_ready, b_out_ovf, b_out_valid;
    logic [9:0]  b_out_acc;
    logic [2:0]  b_out_len;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rca8_sum_accumulator #(.COUNT(4), .ACC_W(16)) dut (
        .clk(clk), .rst(rst), .in_sum(in_sum), .in_valid(in_valid),
        .in_ready(a_in_ready), .flush(flush), .out_acc(a_out_acc),
        .out_len(a_out_len), .out_ovf(a_out_ovf), .out_valid(a_out_valid),
        .out_ready(out_ready)
    );

    rca8_sum_accumulator #(.COUNT(4), .ACC_W(10)) dut10 (
        .clk(clk), .rst(rst), .in_sum(in_sum), .in_valid(in_valid),
        .in_ready(b_in_ready), .flush(flush), .out_acc(b_out_acc),
        .out_len(b_out_len), .out_ovf(b_out_ovf), .out_valid(b_out_valid),
        .out_ready(out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [8:0] v);
        in_valid = 1'b1;
        in_sum   = v;
        tick();
    endtask

    initial begin
        rst = 1'b1; in_sum = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_in_ready",  32'(a_in_ready), 0);
        chk("rst_out_valid", 32'(a_out_valid), 0);
        chk("rst_out_acc",   32'(a_out_acc), 0);
        chk("rst_out_len",   32'(a_out_len), 0);
        chk("rst_out_ovf",   32'(a_out_ovf), 0);
        rst = 1'b0; #1;
        chk("post_rst_in_ready", 32'(a_in_ready), 1);

        // 1+2+3+4 with the output always taken
        feed(1); feed(2); feed(3); feed(4);
        in_valid = 1'b0;
        chk("b1_valid", 32'(a_out_valid), 1);
        chk("b1_acc",   32'(a_out_acc), 10);
        chk("b1_len",   32'(a_out_len), 4);
        chk("b1_ovf",   32'(a_out_ovf), 0);
        chk("b1_in_ready_hold", 32'(a_in_ready), 0);
        tick();
        chk("b1_valid_one_cycle", 32'(a_out_valid), 0);
        chk("b1_in_ready_back",   32'(a_in_ready), 1);
        chk("b1_len_cleared",     32'(a_out_len), 0);

        // 510 x4: wraps at 10 bits, not at 16
        feed(510); feed(510); feed(510); feed(510);
        in_valid = 1'b0;
        chk("ovf16_acc", 32'(a_out_acc), 2040);
        chk("ovf16_ovf", 32'(a_out_ovf), 0);
        chk("ovf10_acc", 32'(b_out_acc), 1016);
        chk("ovf10_ovf", 32'(b_out_ovf), 1);
        chk("ovf10_valid", 32'(b_out_valid), 1);
        tick();
        feed(1); feed(1); feed(1); feed(1);
        in_valid = 1'b0;
        chk("after_ovf10_acc", 32'(b_out_acc), 4);
        chk("after_ovf10_ovf", 32'(b_out_ovf), 0);
        tick();

        // Partial batch closed by a lone flush
        feed(100); feed(200);
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", 32'(a_out_valid), 1);
        chk("flush_acc",   32'(a_out_acc), 300);
        chk("flush_len",   32'(a_out_len), 2);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_empty_valid", 32'(a_out_valid), 0);
        chk("flush_empty_ready", 32'(a_in_ready), 1);

        // Accept and flush in the same cycle
        feed(10);
        flush = 1'b1;
        feed(7);
        flush = 1'b0; in_valid = 1'b0;
        chk("accflush_valid", 32'(a_out_valid), 1);
        chk("accflush_acc",   32'(a_out_acc), 17);
        chk("accflush_len",   32'(a_out_len), 2);
        tick();

        // Backpressure with a pending upstream sample
        out_ready = 1'b0;
        feed(1); feed(2); feed(3); feed(4);
        in_sum = 99;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid",    32'(a_out_valid), 1);
            chk("bp_acc",      32'(a_out_acc), 10);
            chk("bp_len",      32'(a_out_len), 4);
            chk("bp_in_ready", 32'(a_in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(a_out_valid), 0);
        chk("bp_release_len",   32'(a_out_len), 0);
        tick();
        in_valid = 1'b0;
        chk("bp_held_acc", 32'(a_out_acc), 99);
        chk("bp_held_len", 32'(a_out_len), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("bp_held_flush_acc", 32'(a_out_acc), 99);
        tick();

        // Reset discards a partial batch
        feed(50); feed(60);
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        feed(5); feed(5); feed(5); feed(5);
        in_valid = 1'b0;
        chk("rst_mid_acc",   32'(a_out_acc), 20);
        chk("rst_mid_len",   32'(a_out_len), 4);
        chk("rst_mid_valid", 32'(a_out_valid), 1);

        // Reset during HOLD drops the result
        out_ready = 1'b0; rst = 1'b1;
        tick();
        chk("rst_hold_valid", 32'(a_out_valid), 0);
        chk("rst_hold_acc",   32'(a_out_acc), 0);
        rst = 1'b0; out_ready = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
